// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: termination status codes, master FSM states
// and a helper that sizes saturating counters.
package wb_pkg;

   typedef enum logic [1:0] {
      WB_OK              = 2'd0,
      WB_ERR             = 2'd1,
      WB_RETRY_EXHAUSTED = 2'd2,
      WB_TIMEOUT         = 2'd3
   } wb_status_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_BACKOFF = 2'd2,
      S_RESP    = 2'd3
   } wb_master_state_t;

   // Raw status codes for monitors that decode rsp_status without the enum.
   localparam logic [1:0] STATUS_OK              = 2'd0;
   localparam logic [1:0] STATUS_ERR             = 2'd1;
   localparam logic [1:0] STATUS_RETRY_EXHAUSTED = 2'd2;
   localparam logic [1:0] STATUS_TIMEOUT         = 2'd3;

   // Bits needed to hold 0..max_val; never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/wb_sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module wb_sat_counter
   import wb_pkg::*;
#(
   parameter int MAX   = 3,
   parameter int WIDTH = cnt_width(MAX)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != WIDTH'(MAX))) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/wb_single_master.sv
// Wishbone classic single-cycle master: one command in, one bus cycle out,
// with err/rty/ack termination, bounded retry with backoff, and a watchdog.
module wb_single_master
   import wb_pkg::*;
#(
   parameter int           ADDR_WIDTH   = 32,
   parameter int           DATA_WIDTH   = 32,
   parameter int           SELECT_WIDTH = 4,
   parameter int           MAX_RETRY    = 3,
   parameter int           BACKOFF      = 2,
   parameter int           TIMEOUT      = 255,
   parameter logic [1:0]   TGD          = 2'h0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr,
   input  logic [DATA_WIDTH-1:0]   cmd_dat,
   input  logic [SELECT_WIDTH-1:0] cmd_sel,
   output logic                    rsp_valid,
   output logic [1:0]              rsp_status,
   output logic [DATA_WIDTH-1:0]   rsp_dat,
   output logic                    cyc_o,
   output logic                    stb_o,
   output logic                    we_o,
   output logic [ADDR_WIDTH-1:0]   adr_o,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic [SELECT_WIDTH-1:0] sel_o,
   output logic [1:0]              tgd_o,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   input  logic                    ack_i,
   input  logic                    err_i,
   input  logic                    rty_i,
   input  logic [1:0]              tgd_i
);

   localparam int RW = cnt_width(MAX_RETRY);
   localparam int TW = cnt_width(TIMEOUT);
   localparam int BW = cnt_width(BACKOFF);

   wb_master_state_t state, state_next;
   wb_status_t       status_next;
   logic [RW-1:0]    retry_cnt;
   logic [TW-1:0]    tmo_cnt;
   logic [BW-1:0]    bo_cnt;
   logic             accept, retry_inc, tmo_inc, tmo_clr, capture;
   logic             unused_tgd;

   assign tgd_o      = TGD;
   assign unused_tgd = ^tgd_i;
   assign tmo_clr    = accept | (state == S_BACKOFF);

   wb_sat_counter #(.MAX(MAX_RETRY), .WIDTH(RW)) u_retry_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (accept),
      .inc   (retry_inc),
      .count (retry_cnt)
   );

   wb_sat_counter #(.MAX(TIMEOUT), .WIDTH(TW)) u_tmo_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (tmo_clr),
      .inc   (tmo_inc),
      .count (tmo_cnt)
   );

   // Terminations are only looked at in REQ; err wins over rty, rty over ack.
   always_comb begin
      state_next  = state;
      status_next = wb_status_t'(rsp_status);
      accept      = 1'b0;
      retry_inc   = 1'b0;
      tmo_inc     = 1'b0;
      capture     = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               accept     = 1'b1;
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (err_i) begin
               status_next = WB_ERR;
               state_next  = S_RESP;
            end else if (rty_i) begin
               if (retry_cnt == RW'(MAX_RETRY)) begin
                  status_next = WB_RETRY_EXHAUSTED;
                  state_next  = S_RESP;
               end else begin
                  retry_inc  = 1'b1;
                  state_next = S_BACKOFF;
               end
            end else if (ack_i) begin
               status_next = WB_OK;
               capture     = ~we_o;
               state_next  = S_RESP;
            end else begin
               tmo_inc = 1'b1;
               if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  status_next = WB_TIMEOUT;
                  state_next  = S_RESP;
               end
            end
         end
         S_BACKOFF: begin
            if (bo_cnt == BW'(BACKOFF - 1)) state_next = S_REQ;
         end
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Every output is a flop fed from the next state, so cyc/stb fall on the
   // same edge that leaves REQ and reset drops them without a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         cmd_ready  <= 1'b1;
         cyc_o      <= 1'b0;
         stb_o      <= 1'b0;
         we_o       <= 1'b0;
         adr_o      <= '0;
         dat_o      <= '0;
         sel_o      <= '0;
         rsp_valid  <= 1'b0;
         rsp_status <= 2'd0;
         rsp_dat    <= '0;
         bo_cnt     <= '0;
      end else begin
         state      <= state_next;
         cmd_ready  <= (state_next == S_IDLE);
         cyc_o      <= (state_next == S_REQ);
         stb_o      <= (state_next == S_REQ);
         rsp_valid  <= (state_next == S_RESP);
         rsp_status <= status_next;
         bo_cnt     <= (state == S_BACKOFF) ? bo_cnt + 1'b1 : '0;
         if (accept) begin
            we_o  <= cmd_we;
            adr_o <= cmd_adr;
            dat_o <= cmd_dat;
            sel_o <= cmd_sel;
         end
         if (capture) rsp_dat <= dat_i;
      end
   end

endmodule

// File: tb/tb_wb_single_master.sv
// Directed bench for wb_single_master: a configurable Wishbone slave model,
// a command driver that queues expected responses, and a response monitor.
module tb_wb_single_master;

   localparam int EW = 58;   // {status[2], rsp_dat[32], stb_cycles[8], attempts[8], latency[8]}

   logic        clk, reset;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid;
   logic [1:0]  rsp_status;
   logic [31:0] rsp_dat;
   logic        cyc_o, stb_o, we_o;
   logic [31:0] adr_o, dat_o;
   logic [3:0]  sel_o;
   logic [1:0]  tgd_o;
   logic [31:0] dat_i;
   logic        ack_i, err_i, rty_i;
   logic [1:0]  tgd_i;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   wb_single_master #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .SELECT_WIDTH(4),
      .MAX_RETRY(3), .BACKOFF(2), .TIMEOUT(8), .TGD(2'h0)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_dat(rsp_dat),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
      .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .tgd_o(tgd_o),
      .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .tgd_i(tgd_i)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- slave model ----------------
   int   s_wait   = 0;     // stb cycles before termination in each attempt
   int   s_rty    = 0;     // attempts answered with rty before a real answer
   logic s_err    = 1'b0;  // answer with err and ack together
   logic s_silent = 1'b0;  // never terminate
   int   s_cycles, s_attempt;
   logic s_term;

   assign s_term = stb_o && (s_cycles == s_wait) && !s_silent;
   assign rty_i  = s_term && (s_attempt < s_rty);
   assign err_i  = s_term && s_err;
   assign ack_i  = s_term && !rty_i;
   assign tgd_i  = 2'b11;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         s_cycles  <= 0;
         s_attempt <= 0;
      end else begin
         if (cmd_valid && cmd_ready) s_attempt <= 0;
         else if (rty_i)             s_attempt <= s_attempt + 1;
         if (stb_o && !(ack_i || err_i || rty_i)) s_cycles <= s_cycles + 1;
         else                                     s_cycles <= 0;
      end
   end

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic [1:0] st, input logic [31:0] d,
                                        input int stb, input int att, input int lat);
      return {st, d, 8'(stb), 8'(att), 8'(lat)};
   endfunction

   // ---------------- driver ----------------
   logic        cur_we;
   logic [31:0] cur_adr, cur_dat;
   logic [3:0]  cur_sel;
   int          acc_seq = 0;

   task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic expect_rsp, input logic [EW-1:0] e);
      bit done;
      done = 0;
      @(negedge clk);
      cur_we = we; cur_adr = adr; cur_dat = dat; cur_sel = sel;
      cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
      if (expect_rsp) exp_q.push_back(e);
      cmd_valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         if (cmd_ready) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            acc_seq++;
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         cmd_valid = 1'b0;
         check("cmd_accept_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic wait_done(input string name);
      bit empty;
      empty = 0;
      for (int k = 0; k < 60 && !empty; k++) begin
         @(negedge clk);
         empty = (exp_q.size() == 0);
      end
      if (!empty) check(name, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      int   seen, m_lat, m_stb, m_att, m_gap, m_gap_err, m_field_err;
      logic in_cmd, prev_stb, ready_chk;
      logic [EW-1:0] e;
      seen = 0; in_cmd = 0; prev_stb = 0; ready_chk = 0;
      m_lat = 0; m_stb = 0; m_att = 0; m_gap = 0; m_gap_err = 0; m_field_err = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_cmd = 0; prev_stb = 0; ready_chk = 0;
         end else begin
            if (acc_seq != seen) begin
               seen = acc_seq; in_cmd = 1;
               m_lat = 0; m_stb = 0; m_att = 0; m_gap = 0; m_gap_err = 0; m_field_err = 0;
            end
            if (ready_chk) begin
               check("ready_after_rsp", cmd_ready, 1'b1);
               check("rsp_single_pulse", rsp_valid, 1'b0);
               ready_chk = 0;
            end
            if (in_cmd) begin
               m_lat++;
               if (stb_o) begin
                  if (!prev_stb) begin
                     if (m_att > 0 && m_gap != 2) m_gap_err++;
                     m_att++;
                     m_gap = 0;
                  end
                  m_stb++;
                  if (!cyc_o || we_o !== cur_we || adr_o !== cur_adr ||
                      dat_o !== cur_dat || sel_o !== cur_sel) m_field_err++;
               end else if (m_att > 0) begin
                  m_gap++;
               end
            end
            prev_stb = stb_o;
            if (rsp_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_status", 32'(rsp_status), 32'(e[57:56]));
                  check("rsp_dat", rsp_dat, e[55:24]);
                  check("stb_cycles", 32'(m_stb), 32'(e[23:16]));
                  check("attempts", 32'(m_att), 32'(e[15:8]));
                  check("rsp_latency", 32'(m_lat), 32'(e[7:0]));
                  check("backoff_gap", 32'(m_gap_err), 32'd0);
                  check("bus_fields", 32'(m_field_err), 32'd0);
                  check("cyc_low_at_rsp", cyc_o, 1'b0);
               end
               in_cmd = 0;
               ready_chk = 1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
      cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; dat_i = '0;
      cur_we = 0; cur_adr = '0; cur_dat = '0; cur_sel = '0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("reset_cyc", cyc_o, 1'b0);
      check("reset_stb", stb_o, 1'b0);
      check("reset_we", we_o, 1'b0);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_adr", adr_o, 32'd0);
      check("reset_dat", dat_o, 32'd0);
      check("reset_sel", 32'(sel_o), 32'd0);
      check("reset_rsp_dat", rsp_dat, 32'd0);
      check("reset_status", 32'(rsp_status), 32'd0);
      check("reset_ready", cmd_ready, 1'b1);
      check("tgd_o", 32'(tgd_o), 32'd0);

      // write, same-cycle ack
      s_wait = 0; s_rty = 0; s_err = 0; s_silent = 0;
      send(1'b1, 32'h10, 32'hA5A5_0F0F, 4'hF, 1'b1, mk(2'd0, 32'h0, 1, 1, 2));
      wait_done("wait_write");

      // read, ack after 3 wait cycles
      s_wait = 3; dat_i = 32'h1234_5678;
      send(1'b0, 32'h24, 32'h0000_1111, 4'h3, 1'b1, mk(2'd0, 32'h1234_5678, 4, 1, 5));
      wait_done("wait_read");

      // rty twice then ack: three bursts, two 2-cycle gaps
      s_wait = 0; s_rty = 2; dat_i = 32'hFFFF_0000;
      send(1'b1, 32'h30, 32'h0BAD_CAFE, 4'h5, 1'b1, mk(2'd0, 32'h1234_5678, 3, 3, 8));
      wait_done("wait_retry_ok");

      // rty forever: four attempts, then retry exhausted
      s_rty = 100;
      send(1'b0, 32'h34, 32'h0, 4'hF, 1'b1, mk(2'd2, 32'h1234_5678, 4, 4, 11));
      wait_done("wait_retry_exhausted");

      // err and ack together: err wins, rsp_dat untouched
      s_rty = 0; s_err = 1; dat_i = 32'hDEAD_BEEF;
      send(1'b0, 32'h40, 32'h0, 4'hF, 1'b1, mk(2'd1, 32'h1234_5678, 1, 1, 2));
      wait_done("wait_err");

      // silent slave: watchdog after 8 stb cycles
      s_err = 0; s_silent = 1;
      send(1'b1, 32'h44, 32'h5555_AAAA, 4'h8, 1'b1, mk(2'd3, 32'h1234_5678, 8, 1, 9));
      wait_done("wait_timeout");

      // read with one wait cycle and partial selects
      s_silent = 0; s_wait = 1; dat_i = 32'hCAFE_F00D;
      send(1'b0, 32'h48, 32'h0, 4'hC, 1'b1, mk(2'd0, 32'hCAFE_F00D, 2, 1, 3));
      wait_done("wait_read2");

      // reset while stb_o is high: bus drops without a clock edge, no response
      s_wait = 0; s_silent = 1;
      send(1'b1, 32'h50, 32'h1357_9BDF, 4'hF, 1'b0, '0);
      repeat (2) @(negedge clk);
      check("stb_before_reset", stb_o, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("async_cyc_drop", cyc_o, 1'b0);
      check("async_stb_drop", stb_o, 1'b0);
      @(negedge clk);
      #2 reset = 1'b0;
      s_silent = 0;
      repeat (4) @(negedge clk);
      check("post_reset_ready", cmd_ready, 1'b1);
      check("post_reset_rsp_dat", rsp_dat, 32'd0);

      // normal command after reset
      s_wait = 0; dat_i = 32'h0BAD_F00D;
      send(1'b0, 32'h60, 32'h0, 4'hF, 1'b1, mk(2'd0, 32'h0BAD_F00D, 1, 1, 2));
      wait_done("wait_after_reset");

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_single_master.md
Name: wb_single_master

Overview:
- Wishbone classic-cycle bus master that turns a simple command/response handshake into single read or write bus cycles.
- It is the initiator counterpart to the team's register slaves, such as the output registers and the null slave.
- Used by control logic and test sequencers that need bus access without hand-building cyc/stb timing.
- Handles bus termination by ack, err or rty, with bounded retry and a watchdog timeout.

Parameters:
- ADDR_WIDTH, 32: width of cmd_adr and adr_o.
- DATA_WIDTH, 32: width of the data buses.
- SELECT_WIDTH, 4: number of byte-select lanes. DATA_WIDTH must be a multiple of it.
- MAX_RETRY, 3: number of re-issues allowed after rty before giving up. 0 means no retry.
- BACKOFF, 2: idle cycles (cyc_o=0) inserted between an rty and the re-issue. Minimum 1.
- TIMEOUT, 255: cycles a single attempt may wait for termination before abort. Minimum 1.
- TGD, 2'h0: constant driven on tgd_o.

Ports:
- clk  in  1  bus clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; the command is accepted on cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  ADDR_WIDTH  bus address.
- cmd_dat  in  DATA_WIDTH  write data.
- cmd_sel  in  SELECT_WIDTH  byte selects.
- rsp_valid  out  1  one-cycle pulse when the command completes.
- rsp_status  out  2  0 = OK, 1 = ERR, 2 = RETRY_EXHAUSTED, 3 = TIMEOUT.
- rsp_dat  out  DATA_WIDTH  read data, valid with rsp_valid on an OK read; otherwise holds its previous value.
- cyc_o, stb_o, we_o  out  1  Wishbone master controls.
- adr_o  out  ADDR_WIDTH  Wishbone address.
- dat_o  out  DATA_WIDTH  Wishbone write data.
- sel_o  out  SELECT_WIDTH  Wishbone byte selects.
- tgd_o  out  2  data tag, constant TGD.
- dat_i  in  DATA_WIDTH  Wishbone read data.
- ack_i, err_i, rty_i  in  1  cycle terminations.
- tgd_i  in  2  data tag in; ignored.

Behaviour:
- Reset values: cyc_o, stb_o, we_o, rsp_valid = 0; adr_o, dat_o, sel_o, rsp_dat = 0; rsp_status = 0; cmd_ready = 1 (state IDLE). All outputs are registered.
- FSM states: IDLE, REQ, BACKOFF, RESP.
- IDLE:
  - On accept, latch we/adr/dat/sel into the bus output registers.
  - Clear retry_cnt and tmo_cnt; go to REQ.
  - cyc_o and stb_o rise on the next edge.
- REQ: cyc_o = stb_o = 1. Each edge samples the terminations with priority err_i > rty_i > ack_i:
  - err_i: status ERR, go to RESP.
  - rty_i with retry_cnt == MAX_RETRY: status RETRY_EXHAUSTED, go to RESP.
  - rty_i otherwise: retry_cnt += 1, go to BACKOFF.
  - ack_i: status OK; on a read, capture dat_i into rsp_dat; go to RESP.
  - No termination: tmo_cnt += 1. When tmo_cnt reaches TIMEOUT, status TIMEOUT and go to RESP.
- Leaving REQ: cyc_o and stb_o drop on the same edge the FSM leaves REQ. Exactly one stb_o cycle is presented per termination.
- BACKOFF: cyc_o = stb_o = 0 for exactly BACKOFF cycles. tmo_cnt clears; go to REQ with the bus fields unchanged.
- RESP: rsp_valid = 1 for exactly one cycle, with no backpressure; go to IDLE. cmd_ready stays low in RESP.
- Latency with a same-cycle acking slave: accept at edge N, stb_o high during N..N+1, ack sampled at N+1, rsp_valid high in cycle N+1..N+2. Back-to-back throughput is one command per 3 cycles.
- Bus signals never change while stb_o = 1. Inputs are sampled only while in REQ.
- Reset mid-operation: cyc_o and stb_o drop asynchronously; no response is issued; the pending command is discarded.
- Counter widths: retry_cnt is $clog2(MAX_RETRY+1) bits; tmo_cnt is $clog2(TIMEOUT+1) bits. Counters saturate and never wrap.

Decomposition:
- Shared package wb_pkg holds:
  - the enum wb_status_t {WB_OK, WB_ERR, WB_RETRY_EXHAUSTED, WB_TIMEOUT} as 2 bits;
  - the state enum wb_master_state_t;
  - the status localparams shared with future bus monitors.
- Sub-module wb_sat_counter: a parameterised saturating counter with clear and increment. It is instantiated twice, for retry and timeout.

Test Plan:
- Write with a same-cycle-ack slave: cmd we=1, adr=0x10, dat=0xA5A5_0F0F, sel=4'hF → one stb_o cycle with matching fields; rsp_valid at +2 cycles; status 0.
- Read with ack after 3 wait cycles, dat_i=0x1234_5678 → stb_o held 4 cycles with stable fields; rsp_dat=0x1234_5678; status 0.
- Slave asserts rty twice then ack, MAX_RETRY=3 → three stb_o bursts separated by exactly 2 idle cycles; status 0. With rty forever → 4 attempts, then status 2.
- err_i and ack_i asserted together → status 1; rsp_dat unchanged from its prior value.
- Silent slave, TIMEOUT=8 → stb_o high exactly 8 cycles, then rsp_valid with status 3; cmd_ready returns one cycle later.
- reset pulsed while stb_o = 1 → cyc_o and stb_o low immediately without waiting for an edge; no rsp_valid; next command after reset completes normally.
